// File: rtl/avst_arb_pkg.sv
// Shared types and helpers for the Avalon-ST round-robin packet arbiter.
// Holds the two-state FSM enum and the port-index width function.
package avst_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // A 2-port arbiter still needs one index bit, so clamp the minimum at 1.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avst_rr_arbiter_if.sv
// Handshake bundle between N Avalon-ST requesters, the arbiter and one downstream sink.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface avst_rr_arbiter_if
  import avst_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32
);

  localparam int IDX_W = port_idx_w(N_PORTS);

  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        in_ready;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        in_sop;
  logic [N_PORTS-1:0]        in_eop;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_sop;
  logic                      out_eop;
  logic [IDX_W-1:0]          out_channel;
  logic                      wdog_err;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_channel, wdog_err
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_channel, wdog_err
  );

endinterface

// File: rtl/avst_rr_arbiter_picker.sv
// Combinational round-robin priority encoder: the first requesting index at or
// after ptr, wrapping around N.
module rr_picker
  import avst_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = port_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  logic [N-1:0] rot_req;
  logic [W-1:0] rot_idx [N];

  // Slot gi of the rotated view is the port gi positions after the pointer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] sum;
      assign sum         = {1'b0, ptr} + (W+1)'(gi);
      assign rot_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // Scan downwards so the slot closest to the pointer is the last to write.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        found = 1'b1;
        index = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/avst_rr_arbiter.sv
// Packet-locked round-robin arbiter merging N Avalon-ST sinks into one source.
// Optional stall watchdog enabled by defining AVST_ARB_WDOG_EN.
module avst_rr_arbiter
  import avst_arb_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int DATA_W      = 32,
  parameter int WDOG_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  avst_rr_arbiter_if.slave  bus
);

  localparam int               IDX_W     = port_idx_w(N_PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);

  generate
    if (N_PORTS < 2 || N_PORTS > 8 || WDOG_CYCLES < 1) begin : g_param_check
      $error("avst_rr_arbiter: N_PORTS must be 2..8 and WDOG_CYCLES >= 1");
    end
  endgenerate

  arb_state_t       state_reg;
  logic [IDX_W-1:0] grant_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic             pick_found;
  logic [IDX_W-1:0] pick_index;
  logic             locked;
  logic             xfer;
  logic             wdog_fire;

  rr_picker #(
    .N (N_PORTS)
  ) u_picker (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .index (pick_index)
  );

  assign locked = (state_reg == LOCKED);

  // Zero-latency steering: the granted port sees the downstream ready directly.
  always_comb begin
    bus.in_ready    = '0;
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    bus.out_sop     = 1'b0;
    bus.out_eop     = 1'b0;
    bus.out_channel = '0;
    if (locked) begin
      bus.out_valid           = bus.in_valid[grant_reg];
      bus.out_data            = bus.in_data[grant_reg*DATA_W +: DATA_W];
      bus.out_sop             = bus.in_sop[grant_reg];
      bus.out_eop             = bus.in_eop[grant_reg];
      bus.in_ready[grant_reg] = bus.out_ready;
      bus.out_channel         = grant_reg;
    end
  end

  assign xfer        = locked && bus.out_valid && bus.out_ready;
  assign rr_ptr_next = (grant_reg == LAST_PORT) ? '0 : grant_reg + 1'b1;

`ifdef AVST_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_reg;
  logic             wdog_err_reg;

  // Fires on the WDOG_CYCLES-th consecutive locked cycle without a transfer.
  assign wdog_fire = locked && !xfer && (wdog_cnt_reg == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_err_reg <= wdog_fire;
      if (!locked || xfer || wdog_fire) begin
        wdog_cnt_reg <= '0;
      end else begin
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.wdog_err = wdog_err_reg;
`else
  assign wdog_fire    = 1'b0;
  assign bus.wdog_err = 1'b0;
`endif

  // Grant is captured in IDLE and only released by eop or the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_index;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          if ((xfer && bus.out_eop) || wdog_fire) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= rr_ptr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_rr_arbiter.sv
// Directed self-checking bench for avst_rr_arbiter (4 ports, 32-bit data).
// Inputs change 1 time unit after posedge; outputs are checked 3 units later.
module tb_avst_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  avst_rr_arbiter_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  avst_rr_arbiter #(
    .N_PORTS     (N),
    .DATA_W      (DW),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_port(input int p, input logic v, input logic [DW-1:0] d,
                          input logic s, input logic e);
    bus.in_valid[p]         = v;
    bus.in_data[p*DW +: DW] = d;
    bus.in_sop[p]           = s;
    bus.in_eop[p]           = e;
  endtask

  task automatic clear_ports();
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_sop   = '0;
    bus.in_eop   = '0;
  endtask

  task automatic chk_hs(input string tag, input logic v, input logic [N-1:0] rdy,
                        input logic [1:0] ch);
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".ready"}, bus.in_ready, rdy);
    chk({tag, ".chan"},  bus.out_channel, ch);
  endtask

  task automatic chk_beat(input string tag, input logic [DW-1:0] d, input logic s,
                          input logic e);
    chk({tag, ".data"}, bus.out_data, d);
    chk({tag, ".sop"},  bus.out_sop, s);
    chk({tag, ".eop"},  bus.out_eop, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ports();
    bus.out_ready = 1'b1;

    // Reset held with a request present: everything stays quiet.
    repeat (2) cyc();
    set_port(0, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0);
    settle();
    chk_hs("rst", 1'b0, 4'b0000, 2'd0);
    chk("rst.sop", bus.out_sop, 1'b0);
    chk("rst.eop", bus.out_eop, 1'b0);
    chk("rst.wdog", bus.wdog_err, 1'b0);
    cyc(); rst = 1'b0; clear_ports(); settle();
    chk_hs("post_rst", 1'b0, 4'b0000, 2'd0);

    // Ports 0 and 2 request together, 3 beats each.
    cyc();
    set_port(0, 1'b1, 32'hA000_0000, 1'b1, 1'b0);
    set_port(2, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    settle();
    chk_hs("pair.c1", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("pair.c2", 1'b1, 4'b0001, 2'd0);
    chk_beat("pair.c2", 32'hA000_0000, 1'b1, 1'b0);
    cyc(); set_port(0, 1'b1, 32'hA000_0001, 1'b0, 1'b0); settle();
    chk_hs("pair.c3", 1'b1, 4'b0001, 2'd0);
    chk_beat("pair.c3", 32'hA000_0001, 1'b0, 1'b0);
    cyc(); set_port(0, 1'b1, 32'hA000_0002, 1'b0, 1'b1); settle();
    chk_beat("pair.c4", 32'hA000_0002, 1'b0, 1'b1);
    cyc(); set_port(0, 1'b0, '0, 1'b0, 1'b0); settle();
    chk_hs("pair.c5", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("pair.c6", 1'b1, 4'b0100, 2'd2);
    chk_beat("pair.c6", 32'hC000_0000, 1'b1, 1'b0);
    cyc(); set_port(2, 1'b1, 32'hC000_0001, 1'b0, 1'b0); settle();
    chk_beat("pair.c7", 32'hC000_0001, 1'b0, 1'b0);
    cyc();
    set_port(2, 1'b1, 32'hC000_0002, 1'b0, 1'b1);
    set_port(0, 1'b1, 32'hA000_0003, 1'b1, 1'b1);
    settle();
    chk_hs("pair.c8", 1'b1, 4'b0100, 2'd2);
    chk_beat("pair.c8", 32'hC000_0002, 1'b0, 1'b1);
    cyc(); set_port(2, 1'b0, '0, 1'b0, 1'b0); settle();
    chk_hs("pair.c9", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("pair.c10", 1'b1, 4'b0001, 2'd0);
    chk_beat("pair.c10", 32'hA000_0003, 1'b1, 1'b1);
    cyc(); clear_ports(); settle();
    chk_hs("pair.end", 1'b0, 4'b0000, 2'd0);

    // Fresh reset, then all four ports stream single-beat packets.
    cyc(); rst = 1'b1; settle();
    cyc(); rst = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 32'h0000_0100 + p, 1'b1, 1'b1);
    settle();
    chk_hs("rr.start", 1'b0, 4'b0000, 2'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(); settle();
      chk_hs($sformatf("rr.g%0d", k), 1'b1, 4'(1 << (k % N)), 2'(k % N));
      chk($sformatf("rr.g%0d.data", k), bus.out_data, 32'h0000_0100 + (k % N));
      cyc();
      if (k == 7) clear_ports();
      settle();
      chk_hs($sformatf("rr.b%0d", k), 1'b0, 4'b0000, 2'd0);
    end

    // Port 1 four-beat packet with a 2-cycle stall, an in_valid gap, and port 2 waiting.
    cyc(); set_port(1, 1'b1, 32'hD000_0000, 1'b1, 1'b0); settle();
    chk_hs("stall.c1", 1'b0, 4'b0000, 2'd0);
    cyc(); set_port(2, 1'b1, 32'hF000_0000, 1'b1, 1'b1); settle();
    chk_hs("stall.b1", 1'b1, 4'b0010, 2'd1);
    chk_beat("stall.b1", 32'hD000_0000, 1'b1, 1'b0);
    cyc(); set_port(1, 1'b1, 32'hD000_0001, 1'b0, 1'b0); bus.out_ready = 1'b0; settle();
    chk_hs("stall.h1", 1'b1, 4'b0000, 2'd1);
    chk_beat("stall.h1", 32'hD000_0001, 1'b0, 1'b0);
    cyc(); settle();
    chk_hs("stall.h2", 1'b1, 4'b0000, 2'd1);
    chk_beat("stall.h2", 32'hD000_0001, 1'b0, 1'b0);
    cyc(); bus.out_ready = 1'b1; settle();
    chk_hs("stall.b2", 1'b1, 4'b0010, 2'd1);
    chk("stall.b2.data", bus.out_data, 32'hD000_0001);
    cyc(); set_port(1, 1'b0, 32'h0, 1'b0, 1'b0); settle();
    chk_hs("stall.gap", 1'b0, 4'b0010, 2'd1);
    cyc(); set_port(1, 1'b1, 32'hD000_0002, 1'b0, 1'b0); settle();
    chk_hs("stall.b3", 1'b1, 4'b0010, 2'd1);
    chk_beat("stall.b3", 32'hD000_0002, 1'b0, 1'b0);
    cyc(); set_port(1, 1'b1, 32'hD000_0003, 1'b0, 1'b1); settle();
    chk_hs("stall.b4", 1'b1, 4'b0010, 2'd1);
    chk_beat("stall.b4", 32'hD000_0003, 1'b0, 1'b1);
    cyc(); set_port(1, 1'b0, '0, 1'b0, 1'b0); settle();
    chk_hs("stall.idle", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("stall.p2", 1'b1, 4'b0100, 2'd2);
    chk_beat("stall.p2", 32'hF000_0000, 1'b1, 1'b1);

    // Port 3 packet abandoned by reset after its second beat.
    cyc(); set_port(2, 1'b0, '0, 1'b0, 1'b0); set_port(3, 1'b1, 32'hE000_0000, 1'b1, 1'b0);
    settle();
    chk_hs("abort.idle", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("abort.b1", 1'b1, 4'b1000, 2'd3);
    chk("abort.b1.data", bus.out_data, 32'hE000_0000);
    cyc(); set_port(3, 1'b1, 32'hE000_0001, 1'b0, 1'b0); settle();
    chk("abort.b2.data", bus.out_data, 32'hE000_0001);
    cyc();
    set_port(3, 1'b1, 32'hE000_0002, 1'b0, 1'b0);
    set_port(1, 1'b1, 32'h6000_0000, 1'b1, 1'b1);
    set_port(2, 1'b1, 32'h7000_0000, 1'b1, 1'b1);
    rst = 1'b1;
    settle();
    chk("abort.pre.valid", bus.out_valid, 1'b1);
    cyc(); rst = 1'b0; settle();
    chk_hs("abort.rst", 1'b0, 4'b0000, 2'd0);
    chk("abort.rst.eop", bus.out_eop, 1'b0);
    chk("abort.rst.sop", bus.out_sop, 1'b0);
    cyc(); settle();
    chk_hs("abort.regrant", 1'b1, 4'b0010, 2'd1);
    chk_beat("abort.regrant", 32'h6000_0000, 1'b1, 1'b1);
    cyc(); clear_ports(); settle();
    chk_hs("abort.end", 1'b0, 4'b0000, 2'd0);

    // Port 0 sends sop then stalls while port 1 waits.
    cyc();
    set_port(0, 1'b1, 32'hB000_0000, 1'b1, 1'b0);
    set_port(1, 1'b1, 32'h9000_0000, 1'b1, 1'b1);
    settle();
    chk_hs("wd.idle", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("wd.sop", 1'b1, 4'b0001, 2'd0);
    chk_beat("wd.sop", 32'hB000_0000, 1'b1, 1'b0);
    cyc(); set_port(0, 1'b0, '0, 1'b0, 1'b0);
`ifdef AVST_ARB_WDOG_EN
    for (int s = 1; s <= WD; s++) begin
      if (s > 1) cyc();
      settle();
      chk_hs($sformatf("wd.s%0d", s), 1'b0, 4'b0001, 2'd0);
      chk($sformatf("wd.s%0d.err", s), bus.wdog_err, 1'b0);
    end
    cyc(); settle();
    chk("wd.fire.err", bus.wdog_err, 1'b1);
    chk_hs("wd.fire", 1'b0, 4'b0000, 2'd0);
    chk("wd.fire.eop", bus.out_eop, 1'b0);
    cyc(); settle();
    chk("wd.after.err", bus.wdog_err, 1'b0);
    chk_hs("wd.p1", 1'b1, 4'b0010, 2'd1);
    chk("wd.p1.data", bus.out_data, 32'h9000_0000);
`else
    for (int s = 1; s <= 100; s++) begin
      if (s > 1) cyc();
      settle();
      chk_hs($sformatf("hold.s%0d", s), 1'b0, 4'b0001, 2'd0);
      chk($sformatf("hold.s%0d.err", s), bus.wdog_err, 1'b0);
    end
    cyc(); set_port(0, 1'b1, 32'hB000_0001, 1'b0, 1'b1); settle();
    chk_hs("hold.eop", 1'b1, 4'b0001, 2'd0);
    chk_beat("hold.eop", 32'hB000_0001, 1'b0, 1'b1);
    cyc(); set_port(0, 1'b0, '0, 1'b0, 1'b0); settle();
    chk_hs("hold.idle", 1'b0, 4'b0000, 2'd0);
    cyc(); settle();
    chk_hs("hold.p1", 1'b1, 4'b0010, 2'd1);
    chk("hold.p1.data", bus.out_data, 32'h9000_0000);
`endif
    cyc(); clear_ports(); settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avst_rr_arbiter.md
AVST_RR_ARBITER -- requirements
Module: avst_rr_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of Avalon-ST sink (requester) ports, range 2..8.
REQ-002 Parameter DATA_W, default 32, data bits per beat.
REQ-003 Parameter WDOG_CYCLES, default 16, stall cycles before watchdog release (used only under REQ-030).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  N_PORTS  per-port beat valid.
REQ-007 in_ready  out  N_PORTS  per-port ready, ready latency 0.
REQ-008 in_data  in  N_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_sop / in_eop  in  N_PORTS each  per-port start/end of packet.
REQ-010 out_valid  out  1  source beat valid toward the downstream FIFO write side.
REQ-011 out_ready  in  1  downstream ready (FIFO not full), ready latency 0.
REQ-012 out_data / out_sop / out_eop  out  DATA_W / 1 / 1  muxed beat from the granted port.
REQ-013 out_channel  out  $clog2(N_PORTS)  index of the granted port.
REQ-014 wdog_err  out  1  one-cycle pulse on watchdog release.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and LOCKED.
REQ-016 In IDLE: all in_ready=0, out_valid=0; if any in_valid=1, select the winner by round-robin from pointer rr_ptr (first i>=rr_ptr with in_valid[i], wrapping), register it as grant, and enter LOCKED next cycle.
REQ-017 Arbitration bubble SHALL be exactly 1 cycle from first in_valid (in IDLE) to first possible transfer.
REQ-018 In LOCKED: out_valid=in_valid[grant], out_data/sop/eop=port grant's signals, in_ready[grant]=out_ready, all other in_ready=0, combinationally (zero latency).
REQ-019 A beat transfers when out_valid && out_ready; non-granted ports SHALL never transfer.
REQ-020 On a transferred beat with out_eop=1: return to IDLE next cycle, rr_ptr <= (grant+1) mod N_PORTS.
REQ-021 Single-beat packet (sop=eop=1): granted, transferred, released; the next grant goes to a different requesting port if one exists.
REQ-022 in_valid[grant] deasserting mid-packet SHALL NOT release the grant (packet lock held).
REQ-023 out_ready=0 SHALL hold grant, out_data and all state unchanged.
REQ-024 out_channel SHALL equal grant in LOCKED, 0 in IDLE.
REQ-025 sop is not checked; the block forwards it unmodified.

Reset
REQ-026 While rst=1: state=IDLE, rr_ptr=0, grant=0, watchdog counter=0.
REQ-027 Outputs during and immediately after reset: in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_channel=0, wdog_err=0.
REQ-028 Reset mid-packet SHALL abandon the packet without emitting eop; first grant after reset goes to the lowest-index requesting port.
REQ-029 out_data is don't-care while out_valid=0.

Configuration
REQ-030 Macro AVST_ARB_WDOG_EN defined: in LOCKED, a counter increments each cycle with no transfer and clears on any transfer; when it reaches WDOG_CYCLES, the grant is released (IDLE, rr_ptr advances as in REQ-020), wdog_err pulses 1 cycle, and no eop is emitted.
REQ-031 Macro undefined: no counter logic, lock held indefinitely, wdog_err tied 0 (port retained).

Structure
REQ-032 Package avst_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the port-index width constant/function.
REQ-033 One sub-module, rr_picker: combinational round-robin priority encoder (req vector, pointer) -> (found, index).

Verification
REQ-034 Ports 0 and 2 request together after reset, each with a 3-beat packet, out_ready=1 -> port 0 granted, beats on cycles 2-4, 1 bubble, port 2 beats on cycles 6-8.
REQ-035 All 4 ports continuously send 1-beat packets -> grant order 0,1,2,3,0,... with out_channel matching.
REQ-036 Port 1 sends a 4-beat packet, out_ready=0 on beats 2-3 for 2 cycles -> data held stable, no other port granted, eop delivered last.
REQ-037 rst asserted after beat 2 of a 4-beat packet from port 3 -> next cycle out_valid=0, all in_ready=0; next grant goes to the lowest requester.
REQ-038 With AVST_ARB_WDOG_EN, WDOG_CYCLES=16: port 0 sends sop and then stalls -> after 16 idle cycles wdog_err=1 for 1 cycle, port 1 (pending) granted after the 1-cycle bubble; without the macro the lock is held for 100 cycles.
